// File: rtl/vector_bit_scanner.sv
// Serialises the set bits of a 32-bit word as leading-one positions, MSB first,
// using an external leading-one detector in a feedback loop (det_vec -> det_pos).
module vector_bit_scanner #(
    parameter int DATA_W     = 32,
    parameter int POS_W      = 6,
    parameter int EMIT_EMPTY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] det_vec,
    input  logic [POS_W-1:0]  det_pos,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [POS_W-1:0]  pos_out,
    output logic [POS_W-1:0]  idx_out,
    output logic              last_out
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [POS_W-1:0] NONE_POS  = POS_W'(DATA_W);
    localparam logic             EMPTY_EMIT = (EMIT_EMPTY != 32'sd0);

    state_t            state_r;
    logic [DATA_W-1:0] work_r;
    logic [POS_W-1:0]  idx_r;

    logic              pos_hit_s;
    logic [4:0]        clr_idx_s;
    logic [DATA_W-1:0] cleared_s;
    logic              last_s;

    // Work word with the currently reported leading one removed; decides last beat.
    always_comb begin
        pos_hit_s = (det_pos < NONE_POS);
        clr_idx_s = 5'd31 - det_pos[4:0];
        cleared_s = work_r;
        if (pos_hit_s) begin
            cleared_s[clr_idx_s] = 1'b0;
        end else begin
            cleared_s = work_r;
        end
        last_s = !pos_hit_s || (cleared_s == {DATA_W{1'b0}});
    end

    // Scan control: load in IDLE, strip one bit per accepted beat in SCAN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            work_r  <= {DATA_W{1'b0}};
            idx_r   <= {POS_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        work_r <= data_in;
                        idx_r  <= {POS_W{1'b0}};
                        if ((data_in != {DATA_W{1'b0}}) || EMPTY_EMIT) begin
                            state_r <= SCAN;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SCAN: begin
                    if (out_ready) begin
                        if (last_s) begin
                            state_r <= IDLE;
                            work_r  <= {DATA_W{1'b0}};
                            idx_r   <= {POS_W{1'b0}};
                        end else begin
                            // A non-last beat always has a real position to clear.
                            work_r <= cleared_s;
                            idx_r  <= idx_r + {{(POS_W-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        state_r <= SCAN;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    work_r  <= {DATA_W{1'b0}};
                    idx_r   <= {POS_W{1'b0}};
                end
            endcase
        end
    end

    // Handshake flags decode the state register; position follows the detector return.
    always_comb begin
        in_ready  = (state_r == IDLE);
        out_valid = (state_r == SCAN);
        det_vec   = work_r;
        idx_out   = idx_r;
        if (state_r == SCAN) begin
            pos_out  = det_pos;
            last_out = last_s;
        end else begin
            pos_out  = {POS_W{1'b0}};
            last_out = 1'b0;
        end
    end

endmodule
